// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory-stage load/store unit
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_type_e;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  // Size code 2'b11 is handled like a word, so bit 1 alone marks a word access.
  function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] lane);
    return ((typ == MEM_H) && lane[0]) || (typ[1] && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects the addressed byte/half of a read word and extends it
module mem_load_align
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]            i_lane,
  input  logic [1:0]            i_type,
  input  logic                  i_sign,
  output logic [DATA_WIDTH-1:0] o_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_ext = i_rdata;
    case (i_type)
      MEM_B:   o_ext = {{24{i_sign & w_byte[7]}}, w_byte};
      MEM_H:   o_ext = {{16{i_sign & w_half[15]}}, w_half};
      default: o_ext = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage load/store unit with req/ack data memory handshake
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [1:0]            MemTypeM,
  input  logic                  MemSignM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  lsu_state_e            r_state;
  logic                  r_req;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [1:0]            r_lane;
  logic [1:0]            r_type;
  logic                  r_sign;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_access;
  logic                  w_misalign;
  logic [1:0]            w_lane;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ext;

  assign w_access   = MemWriteM | (ResultSrcM == RESULT_SRC_MEM);
  assign w_lane     = ALUResultM[1:0];
  assign w_misalign = is_misaligned(MemTypeM, w_lane);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteDataM;
    case (MemTypeM)
      MEM_B: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{WriteDataM[7:0]}};
      end
      MEM_H: begin
        w_be    = 4'b0011 << w_lane;
        w_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
      end
    endcase
  end

  mem_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .i_rdata (mem_rdata),
    .i_lane  (r_lane),
    .i_type  (r_type),
    .i_sign  (r_sign),
    .o_ext   (w_ext)
  );

  // Memory-side outputs are only reloaded when leaving IDLE, so they stay stable until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= 4'b0000;
      r_wdata <= '0;
      r_lane  <= 2'b00;
      r_type  <= 2'b00;
      r_sign  <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access && !w_misalign) begin
            r_we    <= MemWriteM;
            r_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_lane  <= w_lane;
            r_type  <= MemTypeM;
            r_sign  <= MemSignM;
            r_req   <= 1'b1;
            r_state <= REQ;
          end else if (w_access) begin
            r_rdata <= '0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            r_req <= 1'b0;
            if (!r_we) begin
              r_rdata <= w_ext;
            end
            r_state <= DONE;
          end
        end
        DONE: r_state <= IDLE;
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    StallM    = 1'b0;
    MisalignM = 1'b0;
    case (r_state)
      IDLE: begin
        StallM    = w_access & ~w_misalign;
        MisalignM = w_access & w_misalign;
      end
      REQ:     StallM = 1'b1;
      default: StallM = 1'b0;
    endcase
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;
  assign ReadDataM = r_rdata;

endmodule
